// File: rtl/hsv2rgb_if.sv
// Pixel stream bundle for the HSV-to-RGB decoder: input pixel/sideband and converted output.
// The bypass signal exists only when HSV2RGB_BYPASS_EN is defined.
interface hsv2rgb_if;
    localparam int unsigned PIX_W = 24;

    logic             in_valid;
    logic [PIX_W-1:0] pixel_in;
    logic [PIX_W-1:0] pass_in;
    logic             out_valid;
    logic [PIX_W-1:0] pixel_out;
    logic [PIX_W-1:0] pass_thru;
`ifdef HSV2RGB_BYPASS_EN
    logic             bypass;

    modport master (output in_valid, pixel_in, pass_in, bypass,
                    input  out_valid, pixel_out, pass_thru);
    modport slave  (input  in_valid, pixel_in, pass_in, bypass,
                    output out_valid, pixel_out, pass_thru);
`else
    modport master (output in_valid, pixel_in, pass_in,
                    input  out_valid, pixel_out, pass_thru);
    modport slave  (input  in_valid, pixel_in, pass_in,
                    output out_valid, pixel_out, pass_thru);
`endif
endinterface

// File: rtl/hsv2rgb.sv
// Three-stage pipelined HSV-to-RGB decoder with a matched-latency sideband word.
// Optional feature: define HSV2RGB_BYPASS_EN to add a per-pixel bypass that passes pixel_in through raw.
module hsv2rgb (
    input  logic     clk,
    input  logic     rst,
    hsv2rgb_if.slave bus
);
    localparam int unsigned PIX_W = 24;
    localparam int unsigned CH_W  = 8;
    localparam int unsigned HUE_W = 9;
    localparam int unsigned K_W   = 3;
    localparam int unsigned F_W   = 6;
    localparam int unsigned VS_W  = 16;
    localparam int unsigned UP_W  = 24;
    localparam logic [HUE_W-1:0] HUE_WRAP = HUE_W'(360);

    // Stage 1 combinational: hue wrap, sector/fraction, chroma
    logic [HUE_W-1:0] hue;
    logic [HUE_W-1:0] hw;
    logic [K_W-1:0]   k_c;
    logic [F_W-1:0]   f_c;
    logic [CH_W-1:0]  v_c;
    logic [CH_W-1:0]  s8;
    logic [CH_W-1:0]  c_c;

    always_comb begin
        hue = bus.pixel_in[23:15];
        hw  = (hue >= HUE_WRAP) ? hue - HUE_WRAP : hue;
        k_c = '0;
        f_c = F_W'(hw);
        if (hw >= HUE_W'(300)) begin
            k_c = K_W'(5); f_c = F_W'(hw - HUE_W'(300));
        end else if (hw >= HUE_W'(240)) begin
            k_c = K_W'(4); f_c = F_W'(hw - HUE_W'(240));
        end else if (hw >= HUE_W'(180)) begin
            k_c = K_W'(3); f_c = F_W'(hw - HUE_W'(180));
        end else if (hw >= HUE_W'(120)) begin
            k_c = K_W'(2); f_c = F_W'(hw - HUE_W'(120));
        end else if (hw >= HUE_W'(60)) begin
            k_c = K_W'(1); f_c = F_W'(hw - HUE_W'(60));
        end
        v_c = bus.pixel_in[7:0];
        s8  = {bus.pixel_in[14:8], bus.pixel_in[14]};
        c_c = CH_W'((VS_W'(v_c) * VS_W'(s8) + VS_W'(v_c)) >> 8);
    end

    logic             s1_valid;
    logic [K_W-1:0]   s1_k;
    logic [F_W-1:0]   s1_f;
    logic [CH_W-1:0]  s1_v;
    logic [CH_W-1:0]  s1_c;
    logic [PIX_W-1:0] s1_pass;

    // Stage 2 combinational: ramp and minimum
    logic [CH_W-1:0] up_c;
    logic [CH_W-1:0] m_c;

    always_comb begin
        up_c = CH_W'((UP_W'(s1_c) * UP_W'(s1_f) * UP_W'(1093)) >> 16);
        m_c  = s1_v - s1_c;
    end

    logic             s2_valid;
    logic [K_W-1:0]   s2_k;
    logic [CH_W-1:0]  s2_c;
    logic [CH_W-1:0]  s2_up;
    logic [CH_W-1:0]  s2_m;
    logic [PIX_W-1:0] s2_pass;

`ifdef HSV2RGB_BYPASS_EN
    logic             s1_byp;
    logic             s2_byp;
    logic [PIX_W-1:0] s1_raw;
    logic [PIX_W-1:0] s2_raw;
`endif

    // Stage 3 combinational: sector channel select plus offset
    logic [CH_W-1:0]  dn;
    logic [CH_W-1:0]  r_c;
    logic [CH_W-1:0]  g_c;
    logic [CH_W-1:0]  b_c;
    logic [PIX_W-1:0] rgb_c;

    always_comb begin
        dn  = s2_c - s2_up;
        r_c = '0;
        g_c = '0;
        b_c = '0;
        case (s2_k)
            K_W'(0): begin r_c = s2_c;  g_c = s2_up; end
            K_W'(1): begin r_c = dn;    g_c = s2_c;  end
            K_W'(2): begin g_c = s2_c;  b_c = s2_up; end
            K_W'(3): begin g_c = dn;    b_c = s2_c;  end
            K_W'(4): begin r_c = s2_up; b_c = s2_c;  end
            K_W'(5): begin r_c = s2_c;  b_c = dn;    end
            default: ;
        endcase
        rgb_c = {r_c + s2_m, g_c + s2_m, b_c + s2_m};
`ifdef HSV2RGB_BYPASS_EN
        if (s2_byp) rgb_c = s2_raw;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_k          <= '0;
            s1_f          <= '0;
            s1_v          <= '0;
            s1_c          <= '0;
            s1_pass       <= '0;
            s2_valid      <= 1'b0;
            s2_k          <= '0;
            s2_c          <= '0;
            s2_up         <= '0;
            s2_m          <= '0;
            s2_pass       <= '0;
            bus.out_valid <= 1'b0;
            bus.pixel_out <= '0;
            bus.pass_thru <= '0;
`ifdef HSV2RGB_BYPASS_EN
            s1_byp        <= 1'b0;
            s2_byp        <= 1'b0;
            s1_raw        <= '0;
            s2_raw        <= '0;
`endif
        end else begin
            s1_valid      <= bus.in_valid;
            s1_k          <= k_c;
            s1_f          <= f_c;
            s1_v          <= v_c;
            s1_c          <= c_c;
            s1_pass       <= bus.pass_in;
            s2_valid      <= s1_valid;
            s2_k          <= s1_k;
            s2_c          <= s1_c;
            s2_up         <= up_c;
            s2_m          <= m_c;
            s2_pass       <= s1_pass;
            bus.out_valid <= s2_valid;
            if (s2_valid) begin
                bus.pixel_out <= rgb_c;
                bus.pass_thru <= s2_pass;
            end
`ifdef HSV2RGB_BYPASS_EN
            s1_byp        <= bus.bypass;
            s2_byp        <= s1_byp;
            s1_raw        <= bus.pixel_in;
            s2_raw        <= s1_raw;
`endif
        end
    end
endmodule

// File: tb/tb_hsv2rgb.sv
// Self-checking bench for hsv2rgb: directed vector table, latency/reset sequences and a random stream
// checked cycle by cycle against an arithmetic HSV model.
module tb_hsv2rgb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hsv2rgb_if bus ();
    hsv2rgb dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        valid;
        logic        byp;
        logic [23:0] pix;
        logic [23:0] pass;
    } beat_t;

    typedef struct {
        logic [8:0]  h;
        logic [6:0]  s;
        logic [7:0]  v;
        logic [23:0] exp;
    } vec_t;

    int          n_total = 0;
    int          n_pass  = 0;
    beat_t       pipe[$];
    logic [23:0] held_pix  = '0;
    logic [23:0] held_pass = '0;
    vec_t        vecs[8];

    function automatic logic [23:0] ref_rgb(input logic [23:0] p);
        int h, s, v, hw, k, f, s8, c, m, up, dn, r, g, b;
        h  = int'(p[23:15]);
        s  = int'(p[14:8]);
        v  = int'(p[7:0]);
        hw = (h >= 360) ? h - 360 : h;
        k  = hw / 60;
        f  = hw % 60;
        s8 = s * 2 + ((s >= 64) ? 1 : 0);
        c  = (v * s8 + v) / 256;
        m  = v - c;
        up = (c * f * 1093) / 65536;
        dn = c - up;
        r = 0; g = 0; b = 0;
        case (k)
            0: begin r = c;  g = up; end
            1: begin r = dn; g = c;  end
            2: begin g = c;  b = up; end
            3: begin g = dn; b = c;  end
            4: begin r = up; b = c;  end
            default: begin r = c; b = dn; end
        endcase
        return {8'(r + m), 8'(g + m), 8'(b + m)};
    endfunction

    function automatic logic [23:0] ref_out(input beat_t e);
`ifdef HSV2RGB_BYPASS_EN
        if (e.byp) return e.pix;
`endif
        return ref_rgb(e.pix);
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock: drive inputs, advance, then compare all outputs against the model.
    task automatic step(input logic r, input logic v, input logic b,
                        input logic [23:0] pix, input logic [23:0] pas);
        beat_t e;
        rst          = r;
        bus.in_valid = v;
        bus.pixel_in = pix;
        bus.pass_in  = pas;
`ifdef HSV2RGB_BYPASS_EN
        bus.bypass   = b;
`endif
        @(posedge clk);
        #1;
        if (r) begin
            pipe = {};
            pipe.push_back('0);
            pipe.push_back('0);
            held_pix  = '0;
            held_pass = '0;
            e = '0;
        end else begin
            pipe.push_back('{valid: v, byp: b, pix: pix, pass: pas});
            e = pipe.pop_front();
            if (e.valid) begin
                held_pix  = ref_out(e);
                held_pass = e.pass;
            end
        end
        check("out_valid", 24'(bus.out_valid), 24'(e.valid));
        check("pixel_out", bus.pixel_out, held_pix);
        check("pass_thru", bus.pass_thru, held_pass);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
    endtask

    initial begin
        vecs[0] = '{9'd0,   7'd127, 8'd255, 24'hFF0000};
        vecs[1] = '{9'd120, 7'd127, 8'd255, 24'h00FF00};
        vecs[2] = '{9'd240, 7'd127, 8'd255, 24'h0000FF};
        vecs[3] = '{9'd60,  7'd127, 8'd255, 24'hFFFF00};
        vecs[4] = '{9'd30,  7'd127, 8'd255, 24'hFF7F00};
        vecs[5] = '{9'd400, 7'd127, 8'd255, 24'hFFAA00};
        vecs[6] = '{9'd77,  7'd0,   8'd200, 24'hC8C8C8};
        vecs[7] = '{9'd301, 7'd90,  8'd0,   24'h000000};

        rst = 1'b1; bus.in_valid = 1'b0; bus.pixel_in = '0; bus.pass_in = '0;
`ifdef HSV2RGB_BYPASS_EN
        bus.bypass = 1'b0;
`endif
        step(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
        step(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);

        // Directed vectors: single pixel, out_valid must rise exactly on the third clock
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, {vecs[i].h, vecs[i].s, vecs[i].v}, 24'(32'hA50000 + i));
            check("vec_lat1", 24'(bus.out_valid), 24'h0);
            idle();
            check("vec_lat2", 24'(bus.out_valid), 24'h0);
            idle();
            check("vec_lat3", 24'(bus.out_valid), 24'h1);
            check("vec_pixel", bus.pixel_out, vecs[i].exp);
            idle();
            check("vec_hold", bus.pixel_out, vecs[i].exp);
        end

        // Random back-to-back stream with a 2-cycle gap in the middle
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                idle();
                idle();
            end
            step(1'b0, 1'b1, 1'(i % 2), 24'($urandom), 24'($urandom));
        end
        idle(); idle(); idle();

        // Reset with three pixels in flight; the pixel presented with rst is dropped
        step(1'b0, 1'b1, 1'b0, {9'd0, 7'd127, 8'd255}, 24'h111111);
        step(1'b0, 1'b1, 1'b0, {9'd120, 7'd127, 8'd255}, 24'h222222);
        step(1'b0, 1'b1, 1'b0, {9'd240, 7'd127, 8'd255}, 24'h333333);
        step(1'b1, 1'b1, 1'b0, {9'd60, 7'd127, 8'd255}, 24'h444444);
        check("rst_valid", 24'(bus.out_valid), 24'h0);
        check("rst_pixel", bus.pixel_out, 24'h0);
        for (int i = 0; i < 4; i++) begin
            idle();
            check("rst_no_stale", 24'(bus.out_valid), 24'h0);
        end
        step(1'b0, 1'b1, 1'b0, {9'd30, 7'd127, 8'd255}, 24'h555555);
        idle();
        idle();
        check("rst_new_valid", 24'(bus.out_valid), 24'h1);
        check("rst_new_pixel", bus.pixel_out, 24'hFF7F00);
        check("rst_new_pass", bus.pass_thru, 24'h555555);
        idle();

`ifdef HSV2RGB_BYPASS_EN
        // Alternating bypass: raw and converted pixels interleave at unchanged latency
        step(1'b0, 1'b1, 1'b1, {9'd120, 7'd127, 8'd255}, 24'h0A0A0A);
        step(1'b0, 1'b1, 1'b0, {9'd120, 7'd127, 8'd255}, 24'h0B0B0B);
        step(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        check("byp_raw", bus.pixel_out, {9'd120, 7'd127, 8'd255});
        idle();
        check("byp_conv", bus.pixel_out, 24'h00FF00);
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 1'(i % 2), 24'($urandom), 24'($urandom));
        idle(); idle(); idle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
